// File: rtl/ddfs_pkg.sv
// Shared types and constants for the ddfs output-side blocks.
// Used by ddfs_freq_meter and its crossing detector.
package ddfs_pkg;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      WAIT_FIRST = 2'd1,
      MEASURE    = 2'd2,
      DONE       = 2'd3
   } state_t;

   localparam int PCM_WIDTH   = 16;
   localparam int CLK_FREQ_HZ = 100_000_000;

endpackage

// File: rtl/ddfs_freq_meter_if.sv
// Sample stream, control and result bundle of ddfs_freq_meter.
// Build option: DDFS_FREQ_METER_MINMAX_EN adds pcm_max/pcm_min.
interface ddfs_freq_meter_if
   import ddfs_pkg::*;
#(
   parameter int CNT_WIDTH = 32
);
   logic signed [PCM_WIDTH-1:0] pcm;
   logic                        pcm_valid;
   logic                        start;
   logic [7:0]                  n_periods;
   logic                        busy;
   logic                        done;
   logic                        timeout;
   logic [CNT_WIDTH-1:0]        period_cycles;
`ifdef DDFS_FREQ_METER_MINMAX_EN
   logic signed [PCM_WIDTH-1:0] pcm_max;
   logic signed [PCM_WIDTH-1:0] pcm_min;

   modport master (
      output pcm, pcm_valid, start, n_periods,
      input  busy, done, timeout, period_cycles, pcm_max, pcm_min
   );
   modport slave (
      input  pcm, pcm_valid, start, n_periods,
      output busy, done, timeout, period_cycles, pcm_max, pcm_min
   );
`else
   modport master (
      output pcm, pcm_valid, start, n_periods,
      input  busy, done, timeout, period_cycles
   );
   modport slave (
      input  pcm, pcm_valid, start, n_periods,
      output busy, done, timeout, period_cycles
   );
`endif
endinterface

// File: rtl/ddfs_freq_meter_zero_cross_det.sv
// Schmitt-style rising zero-crossing detector: arm at pcm <= -HYST,
// fire on the first valid sample >= +HYST afterwards.
module zero_cross_det
   import ddfs_pkg::*;
#(
   parameter int HYST = 256
) (
   input  logic                        clk,
   input  logic                        reset_n,
   input  logic                        clear,
   input  logic signed [PCM_WIDTH-1:0] pcm,
   input  logic                        pcm_valid,
   output logic                        xing
);
   localparam logic signed [PCM_WIDTH-1:0] POS_TH = PCM_WIDTH'(HYST);
   localparam logic signed [PCM_WIDTH-1:0] NEG_TH = PCM_WIDTH'(-HYST);

   logic armed_r;

   // Combinational so the FSM can act on the same edge that accepts the sample.
   assign xing = pcm_valid && armed_r && !clear && (pcm >= POS_TH);

   // Armed flag; clear wins so a half-cycle begun before start is forgotten.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         armed_r <= 1'b0;
      end else if (clear) begin
         armed_r <= 1'b0;
      end else if (pcm_valid && (pcm <= NEG_TH)) begin
         armed_r <= 1'b1;
      end else if (xing) begin
         armed_r <= 1'b0;
      end
   end
endmodule

// File: rtl/ddfs_freq_meter.sv
// Measures the cycle span of N rising crossings of the ddfs PCM stream.
// Build option: DDFS_FREQ_METER_MINMAX_EN also captures the signed sample range.
module ddfs_freq_meter
   import ddfs_pkg::*;
#(
   parameter int CNT_WIDTH      = 32,
   parameter int HYST           = 256,
   parameter int TIMEOUT_CYCLES = 100_000_000
) (
   input  logic             clk,
   input  logic             reset_n,
   ddfs_freq_meter_if.slave bus
);
   localparam int                    TCNT_WIDTH = $clog2(TIMEOUT_CYCLES) + 1;
   localparam logic [TCNT_WIDTH-1:0] TCNT_LAST  = TCNT_WIDTH'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_WIDTH-1:0]  CCNT_ONE   = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

   state_t                 state_r, state_next_s;
   logic                   xing_s, clear_s, load_s, first_s, final_s, tout_s;
   logic                   last_s, tmo_s;
   logic [7:0]             nlat_r, pcnt_r;
   logic [TCNT_WIDTH-1:0]  tcnt_r;
   logic [CNT_WIDTH-1:0]   ccnt_r, period_r;
   logic                   busy_r, done_r, timeout_r;

   zero_cross_det #(.HYST(HYST)) u_det (
      .clk       (clk),
      .reset_n   (reset_n),
      .clear     (clear_s),
      .pcm       (bus.pcm),
      .pcm_valid (bus.pcm_valid),
      .xing      (xing_s)
   );

   assign last_s = ((pcnt_r + 8'd1) == nlat_r);
   assign tmo_s  = (tcnt_r == TCNT_LAST);

   // State register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Next state and one-cycle control strobes; timeout beats a final crossing.
   always_comb begin
      state_next_s = state_r;
      clear_s      = 1'b0;
      load_s       = 1'b0;
      first_s      = 1'b0;
      final_s      = 1'b0;
      tout_s       = 1'b0;
      case (state_r)
         IDLE: begin
            if (bus.start) begin
               state_next_s = WAIT_FIRST;
               clear_s      = 1'b1;
               load_s       = 1'b1;
            end else begin
               state_next_s = IDLE;
            end
         end
         WAIT_FIRST: begin
            if (tmo_s) begin
               state_next_s = IDLE;
               tout_s       = 1'b1;
            end else if (xing_s) begin
               state_next_s = MEASURE;
               first_s      = 1'b1;
            end else begin
               state_next_s = WAIT_FIRST;
            end
         end
         MEASURE: begin
            if (tmo_s) begin
               state_next_s = IDLE;
               tout_s       = 1'b1;
            end else if (xing_s && last_s) begin
               state_next_s = DONE;
               final_s      = 1'b1;
            end else begin
               state_next_s = MEASURE;
            end
         end
         DONE: begin
            state_next_s = IDLE;
         end
         default: begin
            state_next_s = IDLE;
         end
      endcase
   end

   // Period/cycle/timeout counters, result register and registered status outputs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         nlat_r    <= 8'd0;
         pcnt_r    <= 8'd0;
         tcnt_r    <= '0;
         ccnt_r    <= '0;
         period_r  <= '0;
         busy_r    <= 1'b0;
         done_r    <= 1'b0;
         timeout_r <= 1'b0;
      end else begin
         if (load_s) begin
            nlat_r <= (bus.n_periods == 8'd0) ? 8'd1 : bus.n_periods;
            tcnt_r <= '0;
         end else if ((state_r == WAIT_FIRST) || (state_r == MEASURE)) begin
            tcnt_r <= tcnt_r + TCNT_WIDTH'(1);
         end
         if (first_s) begin
            ccnt_r <= CCNT_ONE;
            pcnt_r <= 8'd0;
         end else if (state_r == MEASURE) begin
            if (ccnt_r != {CNT_WIDTH{1'b1}}) begin
               ccnt_r <= ccnt_r + CCNT_ONE;
            end
            if (xing_s) begin
               pcnt_r <= pcnt_r + 8'd1;
            end
         end
         if (final_s) begin
            period_r <= ccnt_r;
         end
         busy_r    <= (state_next_s == WAIT_FIRST) || (state_next_s == MEASURE);
         done_r    <= (state_next_s == DONE);
         timeout_r <= tout_s;
      end
   end

   assign bus.busy          = busy_r;
   assign bus.done          = done_r;
   assign bus.timeout       = timeout_r;
   assign bus.period_cycles = period_r;

`ifdef DDFS_FREQ_METER_MINMAX_EN
   logic signed [PCM_WIDTH-1:0] max_r, min_r, max_upd_s, min_upd_s;
   logic signed [PCM_WIDTH-1:0] pcm_max_r, pcm_min_r;

   assign max_upd_s = (bus.pcm_valid && (bus.pcm > max_r)) ? bus.pcm : max_r;
   assign min_upd_s = (bus.pcm_valid && (bus.pcm < min_r)) ? bus.pcm : min_r;

   // Running signed range from the first crossing sample; published with the result.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         max_r     <= 16'sd0;
         min_r     <= 16'sd0;
         pcm_max_r <= 16'sd0;
         pcm_min_r <= 16'sd0;
      end else begin
         if (first_s) begin
            max_r <= bus.pcm;
            min_r <= bus.pcm;
         end else if (state_r == MEASURE) begin
            max_r <= max_upd_s;
            min_r <= min_upd_s;
         end
         if (final_s) begin
            pcm_max_r <= max_upd_s;
            pcm_min_r <= min_upd_s;
         end
      end
   end

   assign bus.pcm_max = pcm_max_r;
   assign bus.pcm_min = pcm_min_r;
`endif
endmodule

// File: tb/tb_ddfs_freq_meter.sv
// Self-checking bench for ddfs_freq_meter: square-wave PCM source, vector table,
// scoreboard of expected done/timeout results, plus reset and start-rule sequences.
module tb_ddfs_freq_meter;
   import ddfs_pkg::*;

   localparam int TMO  = 10_000;
   localparam int WAIT = 12_000;

   typedef struct {
      bit          is_to;
      logic [31:0] period;
   } exp_t;

   typedef struct {
      int          per;
      int          div;
      logic [7:0]  n;
      bit          cst;
      bit          exp_to;
      logic [31:0] exp_period;
   } vec_t;

   logic clk = 1'b0;
   logic reset_n;
   int   total = 0;
   int   bad   = 0;
   exp_t sb_q[$];

   int gen_period = 1000;
   int gen_div    = 1;
   bit gen_const  = 1'b0;

   ddfs_freq_meter_if #(.CNT_WIDTH(32)) bus ();

   ddfs_freq_meter #(
      .CNT_WIDTH      (32),
      .HYST           (256),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   // PCM source: square wave of gen_period samples, one valid sample every gen_div cycles
   initial begin
      int c = 0;
      int s = 0;
      bus.pcm       = 16'sd0;
      bus.pcm_valid = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if ((c % gen_div) == 0) begin
            bus.pcm_valid = 1'b1;
            if (gen_const) bus.pcm = 16'sd100;
            else bus.pcm = ((s % gen_period) < (gen_period / 2)) ? 16'sh4000 : -16'sh4000;
            s++;
         end else begin
            bus.pcm_valid = 1'b0;
         end
         c++;
      end
   end

   // Scoreboard: every done/timeout pulse must match the oldest expectation
   always @(negedge clk) begin
      if (reset_n && (bus.done || bus.timeout)) begin
         if (sb_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_pulse: done=%0b timeout=%0b with nothing expected", bus.done, bus.timeout);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            chk("pulse_timeout", {31'd0, bus.timeout}, {31'd0, e.is_to});
            chk("pulse_done", {31'd0, bus.done}, {31'd0, !e.is_to});
            chk("period_cycles", bus.period_cycles, e.period);
`ifdef DDFS_FREQ_METER_MINMAX_EN
            if (!e.is_to) begin
               chk("pcm_max", {16'd0, bus.pcm_max}, 32'h0000_4000);
               chk("pcm_min", {16'd0, bus.pcm_min}, 32'h0000_C000);
            end
`endif
         end
      end
   end

   task automatic pulse_start(input logic [7:0] n);
      @(posedge clk);
      #1;
      bus.start     = 1'b1;
      bus.n_periods = n;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
   endtask

   task automatic wait_result(output bit seen, output int k);
      seen = 1'b0;
      k    = 0;
      while (!seen && (k < WAIT)) begin
         @(posedge clk);
         #1;
         k++;
         if (bus.done || bus.timeout) seen = 1'b1;
      end
      if (!seen) begin
         total++;
         bad++;
         $display("FAIL wait_result: no done/timeout within %0d cycles", WAIT);
      end
   endtask

   initial begin
      vec_t        vecs[7];
      logic [31:0] last_period;
      exp_t        e;
      bit          seen;
      int          k;

      vecs[0] = '{per: 1000, div: 1, n: 8'd4,   cst: 1'b0, exp_to: 1'b0, exp_period: 32'd4000};
      vecs[1] = '{per: 500,  div: 1, n: 8'd0,   cst: 1'b0, exp_to: 1'b0, exp_period: 32'd500};
      vecs[2] = '{per: 250,  div: 4, n: 8'd1,   cst: 1'b0, exp_to: 1'b0, exp_period: 32'd1000};
      vecs[3] = '{per: 300,  div: 1, n: 8'd3,   cst: 1'b0, exp_to: 1'b0, exp_period: 32'd900};
      vecs[4] = '{per: 2,    div: 1, n: 8'd1,   cst: 1'b0, exp_to: 1'b0, exp_period: 32'd2};
      vecs[5] = '{per: 40,   div: 1, n: 8'd200, cst: 1'b0, exp_to: 1'b0, exp_period: 32'd8000};
      vecs[6] = '{per: 500,  div: 1, n: 8'd1,   cst: 1'b1, exp_to: 1'b1, exp_period: 32'd0};

      reset_n       = 1'b0;
      bus.start     = 1'b0;
      bus.n_periods = 8'd0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_busy", {31'd0, bus.busy}, 32'd0);
      chk("reset_done", {31'd0, bus.done}, 32'd0);
      chk("reset_timeout", {31'd0, bus.timeout}, 32'd0);
      chk("reset_period", bus.period_cycles, 32'd0);
      reset_n     = 1'b1;
      last_period = 32'd0;

      for (int i = 0; i < 7; i++) begin
         gen_period = vecs[i].per;
         gen_div    = vecs[i].div;
         gen_const  = vecs[i].cst;
         repeat (4) @(posedge clk);
         e.is_to  = vecs[i].exp_to;
         e.period = vecs[i].exp_to ? last_period : vecs[i].exp_period;
         sb_q.push_back(e);
         pulse_start(vecs[i].n);
         chk("busy_after_start", {31'd0, bus.busy}, 32'd1);
         wait_result(seen, k);
         if (vecs[i].exp_to) chk("timeout_latency", k, TMO);
         repeat (2) @(posedge clk);
         #1;
         chk("busy_after_end", {31'd0, bus.busy}, 32'd0);
         if (!vecs[i].exp_to) last_period = vecs[i].exp_period;
      end

      // Reset in the middle of a measurement: no pulse, result cleared
      gen_const  = 1'b0;
      gen_period = 800;
      gen_div    = 1;
      pulse_start(8'd2);
      repeat (1500) @(posedge clk);
      #1;
      reset_n = 1'b0;
      @(posedge clk);
      #1;
      chk("midreset_busy", {31'd0, bus.busy}, 32'd0);
      chk("midreset_done", {31'd0, bus.done}, 32'd0);
      chk("midreset_period", bus.period_cycles, 32'd0);
      reset_n = 1'b1;
      repeat (3) @(posedge clk);

      // Fresh measurement; a second start while busy must not change N
      e.is_to  = 1'b0;
      e.period = 32'd1600;
      sb_q.push_back(e);
      pulse_start(8'd2);
      repeat (50) @(posedge clk);
      pulse_start(8'd1);
      chk("busy_after_ignored_start", {31'd0, bus.busy}, 32'd1);
      wait_result(seen, k);

      // start raised during the DONE cycle is ignored as well
      bus.start     = 1'b1;
      bus.n_periods = 8'd1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      chk("start_in_done_busy", {31'd0, bus.busy}, 32'd0);
      repeat (2000) @(posedge clk);
      #1;
      chk("idle_busy", {31'd0, bus.busy}, 32'd0);
      chk("scoreboard_empty", sb_q.size(), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
